inst_sram_resp: RTL and testbench

- Responder end of the instruction SRAM interface.
- Sits opposite the fetch stage, which drives en/wen/addr/wdata and samples rdata one cycle later.
- Models a synchronous, word-organised, byte-writable SRAM with a one-cycle read latency.
- rdata is held stable while no request is issued, so a stalled fetch keeps its instruction.
- Adds a side-band preload port, an address-error flag and a read counter for bring-up and performance.

---
 rtl/inst_sram_resp_pkg.sv | 27 ++
 rtl/inst_sram_resp_sram_byte_array.sv | 38 +++
 rtl/inst_sram_resp.sv | 99 +++++++++
 tb/tb_inst_sram_resp.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_sram_resp_pkg.sv
// Shared constants and request classification for the instruction SRAM responder.
// The fetch stage derives its reset PC (INST_SRAM_BASE - 4) from INST_SRAM_BASE.
package inst_sram_resp_pkg;

  localparam logic [31:0] INST_SRAM_BASE       = 32'hbfc00000;
  localparam int          INST_SRAM_DEPTH_LOG2 = 12;
  localparam int          BYTE_LANES           = 4;

  typedef enum logic [1:0] {
    REQ_IDLE  = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2,
    REQ_BAD   = 2'd3
  } req_kind_e;

  function automatic req_kind_e classify(input logic en, input logic wr, input logic in_range);
    req_kind_e k;
    k = REQ_IDLE;
    if (en) begin
      if (!in_range)  k = REQ_BAD;
      else if (wr)    k = REQ_WRITE;
      else            k = REQ_READ;
    end
    return k;
  endfunction

endpackage

// File: rtl/inst_sram_resp_sram_byte_array.sv
// Reset-free word array with a byte-enabled write port, a priority full-word
// preload port and a synchronous read-first read port.
module sram_byte_array
  import inst_sram_resp_pkg::*;
#(
  parameter int AW = INST_SRAM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [BYTE_LANES-1:0] wbe_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  ld_we_i,
  input  logic [AW-1:0]         ld_addr_i,
  input  logic [31:0]           ld_data_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  // Read samples the pre-edge word; the preload assignment comes last so it
  // overrides every byte lane of a same-index write.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
    if (we_i) begin
      for (int b = 0; b < BYTE_LANES; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (ld_we_i) mem_q[ld_addr_i] <= ld_data_i;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder: qualifies fetch requests, returns read-first data
// one cycle later, flags bad addresses and counts accepted reads.
module inst_sram_resp
  import inst_sram_resp_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = INST_SRAM_BASE,
  parameter int          DEPTH_LOG2 = INST_SRAM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inst_sram_en,
  input  logic [3:0]            inst_sram_wen,
  input  logic [31:0]           inst_sram_addr,
  input  logic [31:0]           inst_sram_wdata,
  output logic [31:0]           inst_sram_rdata,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_idx,
  input  logic [31:0]           ld_data,
  output logic                  addr_err,
  output logic [31:0]           rd_cnt
);

  logic [31:0]           off;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  req_kind_e             kind;
  logic                  unused_off;

  assign off        = inst_sram_addr - ADDR_BASE;
  assign in_range   = (off[31:DEPTH_LOG2+2] == '0) && (inst_sram_addr[1:0] == 2'b00);
  assign idx        = off[DEPTH_LOG2+1:2];
  assign unused_off = ^off[1:0];
  assign kind       = classify(inst_sram_en, |inst_sram_wen, in_range);

  // Requests are gated by reset so one caught under an asynchronous reset
  // neither writes the array nor disturbs its read register.
  logic arr_we, arr_re;
  logic [31:0] arr_rdata;

  assign arr_we = (kind == REQ_WRITE) && !reset;
  assign arr_re = ((kind == REQ_READ) || (kind == REQ_WRITE)) && !reset;

  sram_byte_array #(
    .AW (DEPTH_LOG2)
  ) u_array (
    .clk       (clk),
    .we_i      (arr_we),
    .wbe_i     (inst_sram_wen),
    .waddr_i   (idx),
    .wdata_i   (inst_sram_wdata),
    .ld_we_i   (ld_en),
    .ld_addr_i (ld_idx),
    .ld_data_i (ld_data),
    .re_i      (arr_re),
    .raddr_i   (idx),
    .rdata_o   (arr_rdata)
  );

  // zero_q masks the array output after reset and after a bad request; while
  // idle neither it nor the array read register changes, so rdata holds.
  logic        zero_q, zero_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    zero_d = zero_q;
    err_d  = 1'b0;
    cnt_d  = cnt_q;
    case (kind)
      REQ_READ: begin
        zero_d = 1'b0;
        cnt_d  = cnt_q + 32'd1;
      end
      REQ_WRITE: zero_d = 1'b0;
      REQ_BAD: begin
        zero_d = 1'b1;
        err_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_q <= 1'b1;
      err_q  <= 1'b0;
      cnt_q  <= 32'd0;
    end else begin
      zero_q <= zero_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign inst_sram_rdata = zero_q ? 32'h0 : arr_rdata;
  assign addr_err        = err_q;
  assign rd_cnt          = cnt_q;

endmodule

// File: tb/tb_inst_sram_resp.sv
// Randomised and directed bench for inst_sram_resp against a word-array model.
module tb_inst_sram_resp;

  localparam logic [31:0] BASE  = 32'hbfc00000;
  localparam int          DL2   = 12;
  localparam int          DEPTH = 4096;

  logic            clk = 1'b0;
  logic            reset;
  logic            inst_sram_en;
  logic [3:0]      inst_sram_wen;
  logic [31:0]     inst_sram_addr;
  logic [31:0]     inst_sram_wdata;
  logic [31:0]     inst_sram_rdata;
  logic            ld_en;
  logic [DL2-1:0]  ld_idx;
  logic [31:0]     ld_data;
  logic            addr_err;
  logic [31:0]     rd_cnt;

  always #5 clk = ~clk;

  inst_sram_resp #(.ADDR_BASE(BASE), .DEPTH_LOG2(DL2)) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .ld_en           (ld_en),
    .ld_idx          (ld_idx),
    .ld_data         (ld_data),
    .addr_err        (addr_err),
    .rd_cnt          (rd_cnt)
  );

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_rdata;
  logic        exp_err;
  logic [31:0] exp_cnt;
  int          vectors = 0;
  int          miscompares = 0;

  // Applies one cycle of inputs, advances the model, returns 1 ns after the edge.
  task automatic step(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic lde, input logic [DL2-1:0] lidx,
                      input logic [31:0] ldd);
    logic [31:0] off;
    logic [31:0] word;
    int          i;
    inst_sram_en    = en;
    inst_sram_wen   = wen;
    inst_sram_addr  = addr;
    inst_sram_wdata = wdata;
    ld_en           = lde;
    ld_idx          = lidx;
    ld_data         = ldd;
    off = addr - BASE;
    if (en) begin
      if ((off / 4) < DEPTH && (addr % 4) == 0) begin
        i         = int'(off / 4);
        word      = model_mem[i];
        exp_rdata = word;
        exp_err   = 1'b0;
        if (wen == 4'h0) exp_cnt = exp_cnt + 1;
        else begin
          for (int b = 0; b < 4; b++) if (wen[b]) word[8*b +: 8] = wdata[8*b +: 8];
          model_mem[i] = word;
        end
      end else begin
        exp_rdata = 32'h0;
        exp_err   = 1'b1;
      end
    end else begin
      exp_err = 1'b0;
    end
    if (lde) model_mem[lidx] = ldd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, '0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr);
    step(1'b1, 4'h0, addr, 32'h0, 1'b0, '0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    vectors++;
    if (inst_sram_rdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_rdata got %h want %h", inst_sram_rdata, 32'h0);
    end
    vectors++;
    if (addr_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_err got %b want 0", addr_err);
    end
    vectors++;
    if (rd_cnt !== 32'h0) begin
      miscompares++; $display("FAIL reset_cnt got %h want 0", rd_cnt);
    end
    reset = 1'b0;
    exp_rdata = 32'h0; exp_err = 1'b0; exp_cnt = 32'h0;
    for (int i = 0; i < DEPTH; i++) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, DL2'(i), $urandom);
  endtask

  task automatic test_back_to_back();
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, DL2'(0), 32'h3c1d0001);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, DL2'(1), 32'h27bdfff0);
    rd(32'hbfc00000);
    vectors++;
    if (inst_sram_rdata !== 32'h3c1d0001) begin
      miscompares++; $display("FAIL b2b_first got %h want %h", inst_sram_rdata, 32'h3c1d0001);
    end
    rd(32'hbfc00004);
    vectors++;
    if (inst_sram_rdata !== 32'h27bdfff0) begin
      miscompares++; $display("FAIL b2b_second got %h want %h", inst_sram_rdata, 32'h27bdfff0);
    end
    vectors++;
    if (rd_cnt !== 32'd2) begin
      miscompares++; $display("FAIL b2b_cnt got %0d want 2", rd_cnt);
    end
  endtask

  task automatic test_hold();
    rd(32'hbfc00000);
    for (int c = 0; c < 5; c++) begin
      idle();
      vectors++;
      if (inst_sram_rdata !== 32'h3c1d0001 || addr_err !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_%0d got %h/%b want %h/0", c, inst_sram_rdata, addr_err, 32'h3c1d0001);
      end
    end
  endtask

  task automatic test_byte_write();
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, DL2'(2), 32'h11223344);
    step(1'b1, 4'b0101, 32'hbfc00008, 32'haabbccdd, 1'b0, '0, 32'h0);
    vectors++;
    if (inst_sram_rdata !== 32'h11223344) begin
      miscompares++; $display("FAIL wr_readfirst got %h want %h", inst_sram_rdata, 32'h11223344);
    end
    idle();
    rd(32'hbfc00008);
    vectors++;
    if (inst_sram_rdata !== 32'h11bb33dd) begin
      miscompares++; $display("FAIL wr_merge got %h want %h", inst_sram_rdata, 32'h11bb33dd);
    end
  endtask

  task automatic test_bad_addr();
    logic [31:0] bad [3];
    logic [31:0] cnt0;
    bad[0] = 32'hbfc00002; bad[1] = 32'hbfc10000; bad[2] = 32'hbfbffffc;
    cnt0 = rd_cnt;
    for (int k = 0; k < 3; k++) begin
      rd(32'hbfc00004);
      rd(bad[k]);
      vectors++;
      if (inst_sram_rdata !== 32'h0 || addr_err !== 1'b1) begin
        miscompares++; $display("FAIL bad_%0d got %h/%b want 0/1", k, inst_sram_rdata, addr_err);
      end
      idle();
      vectors++;
      if (addr_err !== 1'b0 || inst_sram_rdata !== 32'h0) begin
        miscompares++; $display("FAIL bad_pulse_%0d got %h/%b want 0/0", k, inst_sram_rdata, addr_err);
      end
    end
    vectors++;
    if (rd_cnt !== cnt0 + 32'd3) begin
      miscompares++; $display("FAIL bad_cnt got %0d want %0d", rd_cnt, cnt0 + 32'd3);
    end
  endtask

  task automatic test_preload_collision();
    step(1'b1, 4'hf, 32'hbfc0000c, 32'h0, 1'b1, DL2'(3), 32'hdeadbeef);
    rd(32'hbfc0000c);
    vectors++;
    if (inst_sram_rdata !== 32'hdeadbeef) begin
      miscompares++; $display("FAIL ld_prio got %h want %h", inst_sram_rdata, 32'hdeadbeef);
    end
    step(1'b1, 4'h0, 32'hbfc00014, 32'h0, 1'b1, DL2'(5), 32'h01234567);
    vectors++;
    if (inst_sram_rdata !== exp_rdata) begin
      miscompares++; $display("FAIL rd_ld_same got %h want %h", inst_sram_rdata, exp_rdata);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [3:0]  wen;
    int          idx, sel;
    for (int n = 0; n < 400; n++) begin
      idx = (n % 2 == 0) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1);
      sel = $urandom_range(0, 9);
      case (sel)
        6:       addr = BASE + 32'(idx * 4) + 32'($urandom_range(1, 3));
        7:       addr = BASE - 32'(4 * $urandom_range(1, 100));
        8:       addr = BASE + 32'(4 * (DEPTH + $urandom_range(0, 100)));
        9:       addr = $urandom;
        default: addr = BASE + 32'(idx * 4);
      endcase
      wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      step(1'($urandom_range(0, 3) != 0), wen, addr, $urandom, 1'($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 0) ? DL2'(idx) : DL2'($urandom), $urandom);
      vectors++;
      if (inst_sram_rdata !== exp_rdata || addr_err !== exp_err || rd_cnt !== exp_cnt) begin
        miscompares++;
        $display("FAIL rand_%0d got %h/%b/%0d want %h/%b/%0d", n, inst_sram_rdata, addr_err,
                 rd_cnt, exp_rdata, exp_err, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] keep4, keep0;
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, DL2'(4), 32'h55aa1234);
    rd(32'hbfc00000);
    keep4 = model_mem[4];
    keep0 = model_mem[0];
    inst_sram_en = 1'b1; inst_sram_wen = 4'hf;
    inst_sram_addr = 32'hbfc00010; inst_sram_wdata = 32'hcafef00d; ld_en = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if (inst_sram_rdata !== 32'h0 || rd_cnt !== 32'h0) begin
      miscompares++; $display("FAIL rst_async got %h/%0d want 0/0", inst_sram_rdata, rd_cnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_rdata = 32'h0; exp_err = 1'b0; exp_cnt = 32'h0;
    idle();
    vectors++;
    if (inst_sram_rdata !== 32'h0 || addr_err !== 1'b0) begin
      miscompares++; $display("FAIL rst_hold got %h/%b want 0/0", inst_sram_rdata, addr_err);
    end
    rd(32'hbfc00010);
    vectors++;
    if (inst_sram_rdata !== keep4) begin
      miscompares++; $display("FAIL rst_nowrite got %h want %h", inst_sram_rdata, keep4);
    end
    rd(32'hbfc00000);
    vectors++;
    if (inst_sram_rdata !== keep0 || rd_cnt !== 32'd2) begin
      miscompares++; $display("FAIL rst_survive got %h/%0d want %h/2", inst_sram_rdata, rd_cnt, keep0);
    end
  endtask

  initial begin
    reset = 1'b1;
    inst_sram_en = 1'b0; inst_sram_wen = 4'h0; inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
    ld_en = 1'b0; ld_idx = '0; ld_data = 32'h0;
    exp_rdata = 32'h0; exp_err = 1'b0; exp_cnt = 32'h0;
    test_reset();
    test_back_to_back();
    test_hold();
    test_byte_write();
    test_bad_addr();
    test_preload_collision();
    test_random();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
